// File: rtl/id_ex_pipe.sv
// ID/EX pipeline register with load-use stall, flush bubble and EX hold.
// Optional ID_EX_PERF_EN adds perf_bubbles / perf_hold event counters.
module id_ex_pipe #(
    parameter int XLEN    = 64,
    parameter int ALUOP_W = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               id_valid,
    input  logic [4:0]         id_rs1,
    input  logic [4:0]         id_rs2,
    input  logic [4:0]         id_rd,
    input  logic [XLEN-1:0]    id_op1,
    input  logic [XLEN-1:0]    id_op2,
    input  logic               id_imm,
    input  logic [ALUOP_W-1:0] id_alu_op,
    input  logic               id_is_load,
    input  logic               id_reg_write,
    input  logic               flush,
    input  logic               ex_hold,
    output logic               id_stall,
`ifdef ID_EX_PERF_EN
    output logic [31:0]        perf_bubbles,
    output logic [31:0]        perf_hold,
`endif
    output logic               ex_valid,
    output logic [4:0]         ex_rs1,
    output logic [4:0]         ex_rs2,
    output logic [4:0]         ex_rd,
    output logic [XLEN-1:0]    ex_op1,
    output logic [XLEN-1:0]    ex_op2,
    output logic               ex_imm,
    output logic               ex_is_load,
    output logic               ex_reg_write,
    output logic [ALUOP_W-1:0] ex_alu_op
);

    typedef struct packed {
        logic               valid;
        logic [4:0]         rs1;
        logic [4:0]         rs2;
        logic [4:0]         rd;
        logic [XLEN-1:0]    op1;
        logic [XLEN-1:0]    op2;
        logic               imm;
        logic               is_load;
        logic               reg_write;
        logic [ALUOP_W-1:0] alu_op;
    } slot_t;

    slot_t r_slot;
    slot_t w_bubble;
    slot_t w_load;
    logic  w_luh;
    logic  w_rs1_hit;
    logic  w_rs2_hit;

    assign w_rs1_hit = (id_rs1 == r_slot.rd);
    assign w_rs2_hit = !id_imm && (id_rs2 == r_slot.rd);
    assign w_luh = r_slot.valid && r_slot.is_load && (r_slot.rd != 5'd0)
                && (w_rs1_hit || w_rs2_hit) && id_valid;

    assign id_stall = !rst && (w_luh || ex_hold);

    // Bubble uses rd=0/imm=1 so the forwarding compares never select it.
    always_comb begin
        w_bubble     = '0;
        w_bubble.imm = 1'b1;
    end

    always_comb begin
        w_load           = '0;
        w_load.valid     = id_valid;
        w_load.rs1       = id_rs1;
        w_load.rs2       = id_rs2;
        w_load.rd        = id_reg_write ? id_rd : 5'd0;
        w_load.op1       = id_op1;
        w_load.op2       = id_op2;
        w_load.imm       = id_imm;
        w_load.is_load   = id_is_load;
        w_load.reg_write = id_reg_write;
        w_load.alu_op    = id_alu_op;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_slot <= '0;
        end else if (!ex_hold) begin
            if (flush || w_luh) begin
                r_slot <= w_bubble;
            end else begin
                r_slot <= w_load;
            end
        end
    end

    assign ex_valid     = r_slot.valid;
    assign ex_rs1       = r_slot.rs1;
    assign ex_rs2       = r_slot.rs2;
    assign ex_rd        = r_slot.rd;
    assign ex_op1       = r_slot.op1;
    assign ex_op2       = r_slot.op2;
    assign ex_imm       = r_slot.imm;
    assign ex_is_load   = r_slot.is_load;
    assign ex_reg_write = r_slot.reg_write;
    assign ex_alu_op    = r_slot.alu_op;

`ifdef ID_EX_PERF_EN
    logic [31:0] r_perf_bubbles;
    logic [31:0] r_perf_hold;

    // Only hazard bubbles count; a flush bubble is a redirect, not a stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_bubbles <= '0;
            r_perf_hold    <= '0;
        end else if (ex_hold) begin
            r_perf_hold <= r_perf_hold + 32'd1;
        end else if (w_luh && !flush) begin
            r_perf_bubbles <= r_perf_bubbles + 32'd1;
        end
    end

    assign perf_bubbles = r_perf_bubbles;
    assign perf_hold    = r_perf_hold;
`endif

endmodule
